// File: rtl/sd_init_ctrl.sv
// SD card SPI-mode init sequencer: power-up dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop, optional CMD58.
// Latency: one command per SEND/WAIT/EVAL pass; EVAL is one cycle after the response is captured.
// Backpressure: cmd_req is held, with idx/arg/crc stable, until cmd_ack; dummy_req is held until dummy_done.
//
// Ports: i_sclk/i_rst (sync, active-high); i_init_start pulse; dummy clock handshake
// (o_dummy_req, o_dummy_cnt, i_dummy_done); command engine handshake (o_cmd_req, i_cmd_ack,
// o_cmd_idx/arg/crc, i_resp_valid, i_resp_r1, i_resp_ext, i_resp_timeout); status
// (o_clk_fast, o_init_busy, o_init_done, o_init_err, o_err_code, o_card_v2, o_card_sdhc).
// Optional macro SD_INIT_OCR_READ_EN: issue CMD58 after ACMD41 and report CCS as o_card_sdhc.
module sd_init_ctrl #(
    parameter int PWRUP_CLKS   = 80,
    parameter int CMD0_RETRY   = 8,
    parameter int ACMD41_RETRY = 1000
) (
    input  logic        i_sclk,
    input  logic        i_rst,
    input  logic        i_init_start,
    output logic        o_dummy_req,
    output logic [7:0]  o_dummy_cnt,
    input  logic        i_dummy_done,
    output logic        o_cmd_req,
    input  logic        i_cmd_ack,
    output logic [5:0]  o_cmd_idx,
    output logic [31:0] o_cmd_arg,
    output logic [6:0]  o_cmd_crc,
    input  logic        i_resp_valid,
    input  logic [7:0]  i_resp_r1,
    input  logic [31:0] i_resp_ext,
    input  logic        i_resp_timeout,
    output logic        o_clk_fast,
    output logic        o_init_busy,
    output logic        o_init_done,
    output logic        o_init_err,
    output logic [2:0]  o_err_code,
    output logic        o_card_v2,
    output logic        o_card_sdhc
);
    typedef enum logic [2:0] {S_IDLE, S_PWRUP, S_SEND, S_WAIT, S_EVAL, S_DONE, S_ERR} state_t;
    typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58} cmd_t;

    localparam logic [15:0] L_CMD0_MAX   = 16'(CMD0_RETRY);
    localparam logic [15:0] L_ACMD41_MAX = 16'(ACMD41_RETRY);

    state_t      r_state, w_state;
    cmd_t        r_cmd, w_cmd;
    logic [15:0] r_cmd0_cnt, w_cmd0_cnt, r_acmd_cnt, w_acmd_cnt;
    logic [7:0]  r_r1, w_r1;
    logic [11:0] r_ext12, w_ext12;
    logic        r_done, w_done, r_err, w_err, r_fast, w_fast, r_v2, w_v2;
    logic [2:0]  r_code, w_code;
    logic        w_ok, w_fail;
    logic [2:0]  w_fail_code;
    logic [15:0] w_cmd0_inc, w_acmd_inc;
    logic [5:0]  w_idx;
    logic [31:0] w_arg;
    logic [6:0]  w_crc;
    logic        w_unused;
`ifdef SD_INIT_OCR_READ_EN
    logic        r_ccs, w_ccs, r_sdhc, w_sdhc;
    assign w_unused = ^{i_resp_ext[31], i_resp_ext[29:12]};
`else
    assign w_unused = ^i_resp_ext[31:12];
`endif

    assign w_cmd0_inc = r_cmd0_cnt + 16'd1;
    assign w_acmd_inc = r_acmd_cnt + 16'd1;

    // Command fields are decoded from the held command register so they stay
    // constant for the whole SEND phase regardless of ack delay.
    always_comb begin
        w_idx = 6'd0;
        w_arg = 32'd0;
        w_crc = 7'h7F;
        case (r_cmd)
            C_CMD0:   w_crc = 7'h4A;
            C_CMD8:   begin w_idx = 6'd8;  w_arg = 32'h0000_01AA; w_crc = 7'h43; end
            C_CMD55:  w_idx = 6'd55;
            C_ACMD41: begin w_idx = 6'd41; w_arg = r_v2 ? 32'h4000_0000 : 32'd0; end
`ifdef SD_INIT_OCR_READ_EN
            C_CMD58:  w_idx = 6'd58;
`endif
            default:  w_idx = 6'd0;
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_cmd       = r_cmd;
        w_cmd0_cnt  = r_cmd0_cnt;
        w_acmd_cnt  = r_acmd_cnt;
        w_r1        = r_r1;
        w_ext12     = r_ext12;
        w_done      = r_done;
        w_err       = r_err;
        w_fast      = r_fast;
        w_v2        = r_v2;
        w_code      = r_code;
        w_ok        = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = 3'd0;
`ifdef SD_INIT_OCR_READ_EN
        w_ccs       = r_ccs;
        w_sdhc      = r_sdhc;
`endif
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_init_start) begin
                    w_state    = S_PWRUP;
                    w_done     = 1'b0;
                    w_err      = 1'b0;
                    w_code     = 3'd0;
                    w_v2       = 1'b0;
                    w_fast     = 1'b0;
                    w_cmd0_cnt = 16'd0;
                    w_acmd_cnt = 16'd0;
`ifdef SD_INIT_OCR_READ_EN
                    w_sdhc     = 1'b0;
`endif
                end
            end
            S_PWRUP: begin
                if (i_dummy_done) begin
                    w_cmd   = C_CMD0;
                    w_state = S_SEND;
                end
            end
            S_SEND: begin
                if (i_cmd_ack) w_state = S_WAIT;
            end
            S_WAIT: begin
                // Timeout takes priority over a coincident response.
                if (i_resp_timeout) begin
                    w_fail      = 1'b1;
                    w_fail_code = 3'd6;
                end else if (i_resp_valid) begin
                    w_r1    = i_resp_r1;
                    w_ext12 = i_resp_ext[11:0];
`ifdef SD_INIT_OCR_READ_EN
                    w_ccs   = i_resp_ext[30];
`endif
                    w_state = S_EVAL;
                end
            end
            S_EVAL: begin
                w_state = S_SEND;
                case (r_cmd)
                    C_CMD0: begin
                        if (r_r1 == 8'h01) begin
                            w_cmd = C_CMD8;
                        end else begin
                            w_cmd0_cnt = w_cmd0_inc;
                            if (w_cmd0_inc >= L_CMD0_MAX) begin
                                w_fail      = 1'b1;
                                w_fail_code = 3'd1;
                            end
                        end
                    end
                    C_CMD8: begin
                        // A v1 card rejects CMD8 as illegal; that still continues, as v1.
                        if (r_r1 == 8'h01 && r_ext12 == 12'h1AA) begin
                            w_v2  = 1'b1;
                            w_cmd = C_CMD55;
                        end else if (r_r1[2]) begin
                            w_v2  = 1'b0;
                            w_cmd = C_CMD55;
                        end else begin
                            w_fail      = 1'b1;
                            w_fail_code = 3'd2;
                        end
                    end
                    C_CMD55: begin
                        if (r_r1 == 8'h00 || r_r1 == 8'h01) begin
                            w_cmd = C_ACMD41;
                        end else begin
                            w_fail      = 1'b1;
                            w_fail_code = 3'd3;
                        end
                    end
                    C_ACMD41: begin
                        if (r_r1 == 8'h00) begin
`ifdef SD_INIT_OCR_READ_EN
                            w_cmd = C_CMD58;
`else
                            w_ok  = 1'b1;
`endif
                        end else if (r_r1 == 8'h01) begin
                            w_acmd_cnt = w_acmd_inc;
                            if (w_acmd_inc < L_ACMD41_MAX) begin
                                w_cmd = C_CMD55;
                            end else begin
                                w_fail      = 1'b1;
                                w_fail_code = 3'd4;
                            end
                        end else begin
                            w_fail      = 1'b1;
                            w_fail_code = 3'd3;
                        end
                    end
`ifdef SD_INIT_OCR_READ_EN
                    C_CMD58: begin
                        if (r_r1 == 8'h00) begin
                            w_sdhc = r_v2 & r_ccs;
                            w_ok   = 1'b1;
                        end else begin
                            w_fail      = 1'b1;
                            w_fail_code = 3'd5;
                        end
                    end
`endif
                    default: begin
                        w_fail      = 1'b1;
                        w_fail_code = 3'd3;
                    end
                endcase
            end
            default: w_state = S_IDLE;
        endcase

        if (w_fail) begin
            w_state = S_ERR;
            w_err   = 1'b1;
            w_code  = w_fail_code;
            w_fast  = 1'b0;
        end else if (w_ok) begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_fast  = 1'b1;
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= C_CMD0;
            r_cmd0_cnt <= 16'd0;
            r_acmd_cnt <= 16'd0;
            r_r1       <= 8'd0;
            r_ext12    <= 12'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_fast     <= 1'b0;
            r_v2       <= 1'b0;
            r_code     <= 3'd0;
`ifdef SD_INIT_OCR_READ_EN
            r_ccs      <= 1'b0;
            r_sdhc     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_cmd      <= w_cmd;
            r_cmd0_cnt <= w_cmd0_cnt;
            r_acmd_cnt <= w_acmd_cnt;
            r_r1       <= w_r1;
            r_ext12    <= w_ext12;
            r_done     <= w_done;
            r_err      <= w_err;
            r_fast     <= w_fast;
            r_v2       <= w_v2;
            r_code     <= w_code;
`ifdef SD_INIT_OCR_READ_EN
            r_ccs      <= w_ccs;
            r_sdhc     <= w_sdhc;
`endif
        end
    end

    assign o_dummy_req = (r_state == S_PWRUP);
    assign o_dummy_cnt = o_dummy_req ? 8'(PWRUP_CLKS) : 8'd0;
    assign o_cmd_req   = (r_state == S_SEND);
    assign o_cmd_idx   = o_cmd_req ? w_idx : 6'd0;
    assign o_cmd_arg   = o_cmd_req ? w_arg : 32'd0;
    assign o_cmd_crc   = o_cmd_req ? w_crc : 7'd0;
    assign o_init_busy = (r_state == S_PWRUP) || (r_state == S_SEND) ||
                         (r_state == S_WAIT)  || (r_state == S_EVAL);
    assign o_init_done = r_done;
    assign o_init_err  = r_err;
    assign o_err_code  = r_code;
    assign o_clk_fast  = r_fast;
    assign o_card_v2   = r_v2;
`ifdef SD_INIT_OCR_READ_EN
    assign o_card_sdhc = r_sdhc;
`else
    assign o_card_sdhc = 1'b0;
`endif
endmodule

// File: tb/tb_sd_init_ctrl.sv
// Bench for sd_init_ctrl: scripted card/command-engine model drives responses, a monitor
// checks every command handshake and every end-of-sequence status against queued expectations.
// Built with ACMD41_RETRY=4 so the retry-exhaustion case stays short.
module tb_sd_init_ctrl;
    logic        i_sclk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_init_start = 1'b0;
    logic        i_dummy_done = 1'b0;
    logic        i_cmd_ack = 1'b0;
    logic        i_resp_valid = 1'b0;
    logic [7:0]  i_resp_r1 = 8'd0;
    logic [31:0] i_resp_ext = 32'd0;
    logic        i_resp_timeout = 1'b0;
    logic        o_dummy_req, o_cmd_req, o_clk_fast, o_init_busy, o_init_done, o_init_err;
    logic        o_card_v2, o_card_sdhc;
    logic [7:0]  o_dummy_cnt;
    logic [5:0]  o_cmd_idx;
    logic [31:0] o_cmd_arg;
    logic [6:0]  o_cmd_crc;
    logic [2:0]  o_err_code;

`ifdef SD_INIT_OCR_READ_EN
    localparam bit OCR = 1'b1;
`else
    localparam bit OCR = 1'b0;
`endif
    localparam logic [31:0] A41V2 = 32'h4000_0000;
    localparam logic [31:0] R7OK  = 32'h0000_01AA;
    localparam logic [31:0] OCRV  = 32'hC0FF_8000;

    sd_init_ctrl #(.PWRUP_CLKS(80), .CMD0_RETRY(8), .ACMD41_RETRY(4)) dut (
        .i_sclk(i_sclk), .i_rst(i_rst), .i_init_start(i_init_start),
        .o_dummy_req(o_dummy_req), .o_dummy_cnt(o_dummy_cnt), .i_dummy_done(i_dummy_done),
        .o_cmd_req(o_cmd_req), .i_cmd_ack(i_cmd_ack), .o_cmd_idx(o_cmd_idx),
        .o_cmd_arg(o_cmd_arg), .o_cmd_crc(o_cmd_crc), .i_resp_valid(i_resp_valid),
        .i_resp_r1(i_resp_r1), .i_resp_ext(i_resp_ext), .i_resp_timeout(i_resp_timeout),
        .o_clk_fast(o_clk_fast), .o_init_busy(o_init_busy), .o_init_done(o_init_done),
        .o_init_err(o_init_err), .o_err_code(o_err_code), .o_card_v2(o_card_v2),
        .o_card_sdhc(o_card_sdhc)
    );

    always #5 i_sclk = ~i_sclk;

    typedef struct { logic [5:0] idx; logic [31:0] arg; logic [6:0] crc; } cmd_t;
    typedef struct { logic [7:0] r1; logic [31:0] ext; bit tmo; } rsp_t;
    typedef struct { bit done; bit err; logic [2:0] code; bit v2; bit sdhc; bit fast; } sts_t;

    cmd_t exp_q[$];
    rsp_t rsp_q[$];
    sts_t sts_q[$];
    int   n_vec = 0, n_err = 0;
    int   ack_delay = 0;
    int   n_dummy = 0, n_cmd0 = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, req);
        end
    endtask

    // One scripted exchange: the command the DUT must issue and the reply the card gives.
    task automatic xc(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                      input logic [7:0] r1, input logic [31:0] ext, input bit tmo);
        cmd_t c;
        rsp_t r;
        c.idx = idx; c.arg = arg; c.crc = crc;
        r.r1 = r1; r.ext = ext; r.tmo = tmo;
        exp_q.push_back(c);
        rsp_q.push_back(r);
    endtask

    task automatic xs(input bit done, input bit err, input logic [2:0] code,
                      input bit v2, input bit sdhc, input bit fast);
        sts_t s;
        s.done = done; s.err = err; s.code = code; s.v2 = v2; s.sdhc = sdhc; s.fast = fast;
        sts_q.push_back(s);
    endtask

    // Card + command engine model; all drives happen 1 time unit after the rising edge.
    initial begin : engine
        int   st, cnt, dcnt;
        rsp_t r;
        st = 0; cnt = 0; dcnt = 0;
        forever begin
            @(posedge i_sclk); #1;
            i_cmd_ack = 1'b0; i_resp_valid = 1'b0; i_resp_timeout = 1'b0; i_dummy_done = 1'b0;
            if (i_rst) begin
                st = 0; dcnt = 0;
            end else begin
                if (o_dummy_req) begin
                    dcnt++;
                    if (dcnt == 4) begin i_dummy_done = 1'b1; dcnt = 0; end
                end else dcnt = 0;
                case (st)
                    0: if (o_cmd_req) begin
                        if (ack_delay == 0) begin i_cmd_ack = 1'b1; st = 2; cnt = 3; end
                        else begin cnt = ack_delay; st = 1; end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin i_cmd_ack = 1'b1; st = 2; cnt = 3; end
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            st = 0;
                            if (rsp_q.size() == 0) begin
                                n_vec++; n_err++;
                                $display("FAIL rsp_script: got no scripted reply, required one");
                            end else begin
                                r = rsp_q.pop_front();
                                if (r.tmo) i_resp_timeout = 1'b1;
                                else begin
                                    i_resp_r1 = r.r1; i_resp_ext = r.ext; i_resp_valid = 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: samples on the falling edge, pops expectations when the DUT presents them.
    initial begin : monitor
        bit   prev_req, prev_busy, prev_dummy, chk_drop, stable;
        logic [44:0] snap;
        cmd_t c;
        sts_t s;
        prev_req = 0; prev_busy = 0; prev_dummy = 0; chk_drop = 0; stable = 0; snap = '0;
        forever begin
            @(negedge i_sclk);
            if (i_rst) begin
                prev_req = 0; prev_busy = 0; prev_dummy = 0; chk_drop = 0;
            end else begin
                if (o_dummy_req && !prev_dummy) begin
                    n_dummy++;
                    check("dummy_cnt", 64'(o_dummy_cnt), 64'd80);
                end
                prev_dummy = o_dummy_req;
                if (o_cmd_req) begin
                    if (!prev_req) begin snap = {o_cmd_idx, o_cmd_arg, o_cmd_crc}; stable = 1; end
                    else if ({o_cmd_idx, o_cmd_arg, o_cmd_crc} !== snap) stable = 0;
                end
                if (chk_drop) begin
                    check("cmd_req_drop", 64'(o_cmd_req), 64'd0);
                    chk_drop = 0;
                end
                if (o_cmd_req && i_cmd_ack) begin
                    if (o_cmd_idx == 6'd0) n_cmd0++;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL cmd_unexpected: got CMD%0d, required none", o_cmd_idx);
                    end else begin
                        c = exp_q.pop_front();
                        check("cmd_idx", 64'(o_cmd_idx), 64'(c.idx));
                        check("cmd_arg", 64'(o_cmd_arg), 64'(c.arg));
                        check("cmd_crc", 64'(o_cmd_crc), 64'(c.crc));
                        check("cmd_stable", 64'(stable), 64'd1);
                    end
                    chk_drop = 1;
                end
                prev_req = o_cmd_req;
                if (prev_busy && !o_init_busy) begin
                    if (sts_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL sts_unexpected: got end of sequence, required none");
                    end else begin
                        s = sts_q.pop_front();
                        check("sts_done_err_fast", 64'({o_init_done, o_init_err, o_clk_fast}),
                              64'({s.done, s.err, s.fast}));
                        check("sts_err_code", 64'(o_err_code), 64'(s.code));
                        check("sts_v2_sdhc", 64'({o_card_v2, o_card_sdhc}), 64'({s.v2, s.sdhc}));
                    end
                end
                prev_busy = o_init_busy;
            end
        end
    end

    task automatic start_pulse();
        i_init_start = 1'b1;
        @(posedge i_sclk); #1;
        i_init_start = 1'b0;
    endtask

    task automatic finish_case(input string nm, input int d0);
        for (int i = 0; i < 4000 && sts_q.size() != 0; i++) @(posedge i_sclk);
        #1;
        check({nm, ".status_seen"}, 64'(sts_q.size()), 64'd0);
        check({nm, ".cmds_left"}, 64'(exp_q.size()), 64'd0);
        check({nm, ".rsps_left"}, 64'(rsp_q.size()), 64'd0);
        check({nm, ".dummy_reqs"}, 64'(n_dummy - d0), 64'd1);
        repeat (3) @(posedge i_sclk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {o_dummy_req, o_dummy_cnt, o_cmd_req, o_cmd_idx, o_cmd_arg, o_cmd_crc, o_clk_fast,
                o_init_busy, o_init_done, o_init_err, o_err_code, o_card_v2, o_card_sdhc};
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of run, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  d0, c0;
        bit  found;
        repeat (3) @(posedge i_sclk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        i_rst = 1'b0;
        @(posedge i_sclk); #1;

        // A: v2 SDHC card, one ACMD41 retry, slow command engine (ack after 5 cycles).
        ack_delay = 5;
        xc(6'd0,  32'd0, 7'h4A, 8'h01, 32'd0, 0);
        xc(6'd8,  R7OK,  7'h43, 8'h01, R7OK,  0);
        xc(6'd55, 32'd0, 7'h7F, 8'h01, 32'd0, 0);
        xc(6'd41, A41V2, 7'h7F, 8'h01, 32'd0, 0);
        xc(6'd55, 32'd0, 7'h7F, 8'h01, 32'd0, 0);
        xc(6'd41, A41V2, 7'h7F, 8'h00, 32'd0, 0);
        if (OCR) xc(6'd58, 32'd0, 7'h7F, 8'h00, OCRV, 0);
        xs(1, 0, 3'd0, 1, OCR, 1);
        d0 = n_dummy;
        start_pulse();
        repeat (20) @(posedge i_sclk);
        #1;
        start_pulse();
        finish_case("v2_sdhc", d0);

        // B: v1 card rejects CMD8; ACMD41 must carry HCS=0 and CCS is ignored.
        ack_delay = 1;
        xc(6'd0,  32'd0, 7'h4A, 8'h01, 32'd0, 0);
        xc(6'd8,  R7OK,  7'h43, 8'h05, 32'd0, 0);
        xc(6'd55, 32'd0, 7'h7F, 8'h01, 32'd0, 0);
        xc(6'd41, 32'd0, 7'h7F, 8'h01, 32'd0, 0);
        xc(6'd55, 32'd0, 7'h7F, 8'h00, 32'd0, 0);
        xc(6'd41, 32'd0, 7'h7F, 8'h00, 32'd0, 0);
        if (OCR) xc(6'd58, 32'd0, 7'h7F, 8'h00, OCRV, 0);
        xs(1, 0, 3'd0, 0, 0, 1);
        d0 = n_dummy;
        start_pulse();
        finish_case("v1_card", d0);

        // C: CMD0 never answered with idle -> eight attempts then code 1.
        ack_delay = 0;
        for (int i = 0; i < 8; i++) xc(6'd0, 32'd0, 7'h4A, 8'hFF, 32'd0, 0);
        xs(0, 1, 3'd1, 0, 0, 0);
        d0 = n_dummy; c0 = n_cmd0;
        start_pulse();
        finish_case("cmd0_retry", d0);
        check("cmd0_retry.cmd0_count", 64'(n_cmd0 - c0), 64'd8);

        // D: ACMD41 stays busy -> four CMD55/ACMD41 pairs then code 4.
        xc(6'd0, 32'd0, 7'h4A, 8'h01, 32'd0, 0);
        xc(6'd8, R7OK,  7'h43, 8'h01, R7OK,  0);
        for (int i = 0; i < 4; i++) begin
            xc(6'd55, 32'd0, 7'h7F, 8'h01, 32'd0, 0);
            xc(6'd41, A41V2, 7'h7F, 8'h01, 32'd0, 0);
        end
        xs(0, 1, 3'd4, 1, 0, 0);
        d0 = n_dummy;
        start_pulse();
        finish_case("acmd41_retry", d0);

        // E: no response to CMD55 -> code 6.
        xc(6'd0,  32'd0, 7'h4A, 8'h01, 32'd0, 0);
        xc(6'd8,  R7OK,  7'h43, 8'h01, R7OK,  0);
        xc(6'd55, 32'd0, 7'h7F, 8'h00, 32'd0, 1);
        xs(0, 1, 3'd6, 1, 0, 0);
        d0 = n_dummy;
        start_pulse();
        finish_case("cmd55_timeout", d0);

        // F: reset while ACMD41 is being requested.
        ack_delay = 5;
        xc(6'd0,  32'd0, 7'h4A, 8'h01, 32'd0, 0);
        xc(6'd8,  R7OK,  7'h43, 8'h01, R7OK,  0);
        xc(6'd55, 32'd0, 7'h7F, 8'h01, 32'd0, 0);
        start_pulse();
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge i_sclk); #1;
            if (o_cmd_req && o_cmd_idx == 6'd41) found = 1;
        end
        check("rst.reached_acmd41", 64'(found), 64'd1);
        i_rst = 1'b1;
        @(posedge i_sclk); #1;
        check("rst.outputs_cleared", all_outs(), 64'd0);
        @(posedge i_sclk); #1;
        i_rst = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        @(posedge i_sclk); #1;

        // G: fresh start after the reset runs the whole sequence again.
        ack_delay = 0;
        xc(6'd0,  32'd0, 7'h4A, 8'h01, 32'd0, 0);
        xc(6'd8,  R7OK,  7'h43, 8'h01, R7OK,  0);
        xc(6'd55, 32'd0, 7'h7F, 8'h01, 32'd0, 0);
        xc(6'd41, A41V2, 7'h7F, 8'h00, 32'd0, 0);
        if (OCR) xc(6'd58, 32'd0, 7'h7F, 8'h00, 32'h0000_8000, 0);
        xs(1, 0, 3'd0, 1, 0, 1);
        d0 = n_dummy;
        start_pulse();
        finish_case("restart", d0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
